// File: rtl/cardinal_pipe_ctrl.sv
// Pipeline sequencing controller for the cardinal core: hazard detection,
// operand forwarding, branch flush and multi-cycle ALU sequencing.
module cardinal_pipe_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        id_valid,
  input  logic [0:31] id_instr,
  input  logic        br_taken,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic        exwb_bubble,
  output logic        if_flush,
  output logic [0:1]  fwd_a,
  output logic [0:1]  fwd_b,
  output logic        mc_start,
  output logic        mc_busy,
  output logic [0:1]  ctrl_state
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MC_BUSY = 2'b10;

  localparam logic [5:0] OP_RALU  = 6'b101010;
  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_BEZ   = 6'b100010;
  localparam logic [5:0] OP_BNEZ  = 6'b100011;

  localparam logic [5:0] F_VNOT  = 6'b000100;
  localparam logic [5:0] F_VMOV  = 6'b000101;
  localparam logic [5:0] F_VDIV  = 6'b001110;
  localparam logic [5:0] F_VMOD  = 6'b001111;
  localparam logic [5:0] F_VSQEU = 6'b010000;
  localparam logic [5:0] F_VSQOU = 6'b010001;
  localparam logic [5:0] F_VSQRT = 6'b010010;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [4:0] ex_rd, wb_rd;
  logic       ex_wr, ex_ld, ex_mc;
  logic       wb_wr, wb_ld, wb_mc;

  logic [5:0] opcode, func;
  logic [4:0] src_a, src_b, dec_rd;
  logic       use_a, use_b, dec_wr, dec_ld, dec_mc;
  logic       mc_stall, lu_stall;
  logic       unused_bits;

  assign opcode      = id_instr[0:5];
  assign func        = id_instr[26:31];
  assign dec_rd      = id_instr[6:10];
  assign src_b       = id_instr[16:20];
  assign unused_bits = ^{id_instr[21:25], wb_ld, wb_mc};

  always_comb begin
    use_a  = 1'b0;
    use_b  = 1'b0;
    dec_wr = 1'b0;
    dec_ld = 1'b0;
    dec_mc = 1'b0;
    src_a  = id_instr[11:15];
    if (id_valid) begin
      case (opcode)
        OP_RALU: begin
          use_a  = 1'b1;
          use_b  = !(func inside {F_VNOT, F_VMOV, F_VSQEU, F_VSQOU, F_VSQRT});
          dec_wr = 1'b1;
          dec_mc = func inside {F_VDIV, F_VMOD, F_VSQRT};
        end
        OP_LOAD: begin
          dec_wr = 1'b1;
          dec_ld = 1'b1;
        end
        OP_STORE, OP_BEZ, OP_BNEZ: begin
          use_a = 1'b1;
          src_a = id_instr[6:10];
        end
        default: ;
      endcase
    end
  end

  // A multi-cycle op freezes the front of the pipe and masks all ID hazards.
  always_comb begin
    mc_stall = ((state == RUN) && ex_mc) || ((state == MC_BUSY) && (cnt != '0));
    lu_stall = !mc_stall && ex_ld && ex_wr &&
               ((use_a && (ex_rd == src_a)) || (use_b && (ex_rd == src_b)));
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!mc_stall) begin
      if (use_a) begin
        if (ex_wr && !ex_ld && (ex_rd == src_a))   fwd_a = 2'b01;
        else if (wb_wr && (wb_rd == src_a))        fwd_a = 2'b10;
      end
      if (use_b) begin
        if (ex_wr && !ex_ld && (ex_rd == src_b))   fwd_b = 2'b01;
        else if (wb_wr && (wb_rd == src_b))        fwd_b = 2'b10;
      end
    end
  end

  assign pc_hold     = mc_stall | lu_stall;
  assign ifid_hold   = mc_stall | lu_stall;
  assign idex_bubble = lu_stall;
  assign ex_hold     = mc_stall;
  assign exwb_bubble = mc_stall;
  assign if_flush    = br_taken & id_valid & ~pc_hold & ~Reset;
  assign mc_start    = (state == RUN) & ex_mc;
  assign mc_busy     = (state == MC_BUSY);
  assign ctrl_state  = state;

  // While EX re-executes, nothing valid leaves it, so the WB write is dropped.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ex_rd <= '0;
      ex_wr <= 1'b0;
      ex_ld <= 1'b0;
      ex_mc <= 1'b0;
      wb_rd <= '0;
      wb_wr <= 1'b0;
      wb_ld <= 1'b0;
      wb_mc <= 1'b0;
    end else if (ex_hold) begin
      wb_wr <= 1'b0;
    end else begin
      wb_rd <= ex_rd;
      wb_wr <= ex_wr;
      wb_ld <= ex_ld;
      wb_mc <= ex_mc;
      if (idex_bubble) begin
        ex_rd <= '0;
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
        ex_mc <= 1'b0;
      end else begin
        ex_rd <= dec_rd;
        ex_wr <= dec_wr;
        ex_ld <= dec_ld;
        ex_mc <= dec_mc;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc) begin
            state <= MC_BUSY;
            cnt   <= CNT_W'(MC_CYCLES - 2);
          end
        end
        MC_BUSY: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_pipe_ctrl.sv
// Directed scoreboard bench for cardinal_pipe_ctrl; a MC_CYCLES=4 instance
// covers most sequences and a MC_CYCLES=2 instance covers back-to-back mc ops.
module tb_cardinal_pipe_ctrl;

  localparam logic [5:0] OP_RALU = 6'b101010;
  localparam logic [5:0] OP_LOAD = 6'b100000;
  localparam logic [5:0] OP_BEZ  = 6'b100010;
  localparam logic [5:0] F_VOR   = 6'b000010;
  localparam logic [5:0] F_VADD  = 6'b000110;
  localparam logic [5:0] F_VSUB  = 6'b000111;
  localparam logic [5:0] F_VDIV  = 6'b001110;
  localparam logic [5:0] F_VMOD  = 6'b001111;
  localparam logic [5:0] F_VSQRT = 6'b010010;
  localparam logic [13:0] Z = 14'b0;

  logic        Clock, Reset, id_valid, br_taken;
  logic [0:31] id_instr;

  logic        pc_hold, ifid_hold, idex_bubble, ex_hold, exwb_bubble, if_flush;
  logic [0:1]  fwd_a, fwd_b, ctrl_state;
  logic        mc_start, mc_busy;
  logic        pc_hold2, ifid_hold2, idex_bubble2, ex_hold2, exwb_bubble2, if_flush2;
  logic [0:1]  fwd_a2, fwd_b2, ctrl_state2;
  logic        mc_start2, mc_busy2;
  logic [13:0] obs4, obs2;

  typedef struct {
    logic [13:0] exp;
    string       tag;
    bit          sel2;
  } sb_t;

  sb_t sb_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  cardinal_pipe_ctrl #(.MC_CYCLES(4), .CNT_W(4)) u_dut (
    .Clock(Clock), .Reset(Reset), .id_valid(id_valid), .id_instr(id_instr),
    .br_taken(br_taken), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold), .exwb_bubble(exwb_bubble),
    .if_flush(if_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_start(mc_start),
    .mc_busy(mc_busy), .ctrl_state(ctrl_state));

  cardinal_pipe_ctrl #(.MC_CYCLES(2), .CNT_W(4)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .id_valid(id_valid), .id_instr(id_instr),
    .br_taken(br_taken), .pc_hold(pc_hold2), .ifid_hold(ifid_hold2),
    .idex_bubble(idex_bubble2), .ex_hold(ex_hold2), .exwb_bubble(exwb_bubble2),
    .if_flush(if_flush2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mc_start(mc_start2),
    .mc_busy(mc_busy2), .ctrl_state(ctrl_state2));

  assign obs4 = {pc_hold, ifid_hold, idex_bubble, ex_hold, exwb_bubble, if_flush,
                 fwd_a, fwd_b, mc_start, mc_busy, ctrl_state};
  assign obs2 = {pc_hold2, ifid_hold2, idex_bubble2, ex_hold2, exwb_bubble2, if_flush2,
                 fwd_a2, fwd_b2, mc_start2, mc_busy2, ctrl_state2};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [0:31] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic [5:0] fn);
    return {op, rd, ra, rb, 5'b00000, fn};
  endfunction

  function automatic logic [13:0] e(input bit ph, input bit ih, input bit ib,
                                    input bit eh, input bit eb, input bit fl,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input bit ms, input bit mb, input logic [1:0] st);
    return {ph, ih, ib, eh, eb, fl, fa, fb, ms, mb, st};
  endfunction

  task automatic applyStimulus(input logic v, input logic [0:31] ins, input logic br,
                               input logic [13:0] exp, input string tag, input bit sel2);
    sb_t it;
    id_valid = v;
    id_instr = ins;
    br_taken = br;
    it.exp  = exp;
    it.tag  = tag;
    it.sel2 = sel2;
    sb_q.push_back(it);
  endtask

  task automatic checkOutput();
    sb_t         it;
    logic [13:0] obs;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    it  = sb_q.pop_front();
    obs = it.sel2 ? obs2 : obs4;
    assert (obs === it.exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask

  task automatic step(input logic v, input logic [0:31] ins, input logic br,
                      input logic [13:0] exp, input string tag, input bit sel2);
    applyStimulus(v, ins, br, exp, tag, sel2);
    @(negedge Clock);
    checkOutput();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      id_valid = 1'b0;
      id_instr = '0;
      br_taken = 1'b0;
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    logic [0:31] vadd_11;
    logic [0:31] vmod_14;
    logic [0:31] vadd_15;
    logic [0:31] bez_r2;
    vadd_11 = mk(OP_RALU, 11, 1, 2, F_VADD);
    vmod_14 = mk(OP_RALU, 14, 13, 2, F_VMOD);
    vadd_15 = mk(OP_RALU, 15, 13, 14, F_VADD);
    bez_r2  = mk(OP_BEZ, 2, 0, 0, 6'b0);

    // Reset with a live taken branch in ID: every output must still be low.
    Reset = 1'b1;
    id_valid = 1'b0;
    id_instr = '0;
    br_taken = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    applyStimulus(1'b1, bez_r2, 1'b1, Z, "reset_outputs_zero", 1'b0);
    #1 checkOutput();
    #2 Reset = 1'b0;
    id_valid = 1'b0;
    br_taken = 1'b0;
    @(posedge Clock);
    #1;

    step(1'b1, mk(OP_LOAD, 3, 0, 0, 6'b0), 1'b0, Z, "lu_load_in_id", 1'b0);
    step(1'b1, mk(OP_RALU, 5, 3, 4, F_VADD), 1'b0,
         e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00), "lu_stall_cycle", 1'b0);
    step(1'b1, mk(OP_RALU, 5, 3, 4, F_VADD), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2'b00), "lu_fwd_from_wb", 1'b0);
    idle(2);

    step(1'b1, mk(OP_RALU, 7, 1, 2, F_VADD), 1'b0, Z, "raw_producer_in_id", 1'b0);
    step(1'b1, mk(OP_RALU, 8, 7, 7, F_VSUB), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00), "raw_ex_fwd_both", 1'b0);
    step(1'b1, mk(OP_RALU, 9, 7, 0, F_VOR), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2'b00), "raw_wb_fwd_a", 1'b0);
    idle(2);

    step(1'b1, mk(OP_RALU, 10, 1, 2, F_VDIV), 1'b0, Z, "mc_div_in_id", 1'b0);
    step(1'b1, vadd_11, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 2'b00), "mc_start_cycle", 1'b0);
    step(1'b1, vadd_11, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 2'b10), "mc_busy_hold1", 1'b0);
    step(1'b1, vadd_11, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 2'b10), "mc_busy_hold2", 1'b0);
    step(1'b1, vadd_11, 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10), "mc_busy_release", 1'b0);
    step(1'b1, mk(OP_RALU, 12, 11, 10, F_VSUB), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 2'b00), "mc_add_ex_div_wb", 1'b0);
    idle(2);

    step(1'b1, mk(OP_LOAD, 2, 0, 0, 6'b0), 1'b0, Z, "br_load_in_id", 1'b0);
    step(1'b1, bez_r2, 1'b1,
         e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00), "br_stalled_no_flush", 1'b0);
    step(1'b1, bez_r2, 1'b1,
         e(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 2'b00), "br_released_flush", 1'b0);
    idle(2);

    // Back-to-back VSQRT then VMOD on the two-cycle instance.
    step(1'b1, mk(OP_RALU, 13, 1, 0, F_VSQRT), 1'b0, Z, "mc2_sqrt_in_id", 1'b1);
    step(1'b1, vmod_14, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 2'b00), "mc2_sqrt_start", 1'b1);
    step(1'b1, vmod_14, 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1, 2'b10), "mc2_sqrt_release", 1'b1);
    step(1'b1, vadd_15, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 2'b00), "mc2_mod_start", 1'b1);
    step(1'b1, vadd_15, 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 2'b10), "mc2_mod_release", 1'b1);
    step(1'b1, mk(OP_RALU, 16, 14, 0, F_VOR), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2'b00), "mc2_mod_result_wb", 1'b1);
    idle(12);

    // Abort a VDIV with asynchronous reset while cnt is 1.
    step(1'b1, mk(OP_RALU, 10, 1, 2, F_VDIV), 1'b0, Z, "rst_div_in_id", 1'b0);
    step(1'b0, '0, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 2'b00), "rst_div_start", 1'b0);
    step(1'b0, '0, 1'b0,
         e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 2'b10), "rst_busy_cnt2", 1'b0);
    applyStimulus(1'b0, '0, 1'b0,
                  e(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 2'b10), "rst_busy_cnt1", 1'b0);
    @(negedge Clock);
    checkOutput();
    #2 Reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, Z, "rst_async_clear", 1'b0);
    #1 checkOutput();
    @(posedge Clock);
    #2 Reset = 1'b0;
    step(1'b1, mk(OP_RALU, 5, 1, 2, F_VADD), 1'b0, Z, "rst_alu_in_id", 1'b0);
    step(1'b1, mk(OP_RALU, 6, 5, 5, F_VSUB), 1'b0,
         e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00), "rst_alu_ex_no_stall", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
